// File: rtl/des_sched.sv
// des_sched: front-end scheduler for the DES encrypt/decrypt codecs.
// Issues valid/ready requests to the selected codec, holds codec keys stable
// while results are outstanding, bounds in-flight work by response-FIFO
// credit and returns results in issue order.
// Optional macro DES_SCHED_ERR_EN: adds a sticky err output flagging stray or
// simultaneous codec results (both simultaneous results are then captured).
module des_sched #(
    parameter int LAT   = 17,
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [63:0] req_data,
    input  logic [63:0] req_key,
    input  logic        req_mode,
    output logic [63:0] enc_data_i,
    output logic        enc_valid_i,
    output logic [63:0] enc_key,
    input  logic [63:0] enc_data_o,
    input  logic        enc_valid_o,
    output logic [63:0] dec_data_i,
    output logic        dec_valid_i,
    output logic [63:0] dec_key,
    input  logic [63:0] dec_data_o,
    input  logic        dec_valid_o,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_data,
    output logic        rsp_mode
`ifdef DES_SCHED_ERR_EN
    ,
    output logic        err
`endif
);
    localparam int PW   = $clog2(DEPTH);
    localparam int CW   = $clog2(DEPTH + 1);
    // A request stays in flight for LAT+1 cycles, so neither bound can be exceeded.
    localparam int MAXF = (DEPTH < LAT + 1) ? DEPTH : LAT + 1;
    localparam int IW   = $clog2(MAXF + 1);
    localparam int SW   = CW + 2;

    logic            run_reg;
    logic [IW-1:0]   inflight_enc_reg, inflight_dec_reg;
    logic [CW-1:0]   fifo_count_reg;
    logic [PW-1:0]   wr_ptr_reg, rd_ptr_reg, wr_ptr_nxt1;
    logic [63:0]     mem_data [DEPTH];
    logic            mem_mode [DEPTH];
    logic [63:0]     enc_data_i_reg, enc_key_reg, dec_data_i_reg, dec_key_reg;
    logic            enc_valid_i_reg, dec_valid_i_reg;

    logic [SW-1:0]   used_slots, free_slots;
    logic            credit_ok, key_ok, issue, pop;
    logic            enc_take, dec_live, dec_take, push0, push1;
    logic [1:0]      n_push;
    logic [63:0]     slot0_data;
    logic            slot0_mode;
    logic [DEPTH-1:0] wen0, wen1;

    // Credit counts every slot already promised: queued results plus work in the codecs.
    assign used_slots = SW'(fifo_count_reg) + SW'(inflight_enc_reg) + SW'(inflight_dec_reg);
    assign credit_ok  = used_slots < SW'(DEPTH);
    assign key_ok     = req_mode ? ((req_key == enc_key_reg) || (inflight_enc_reg == '0))
                                 : ((req_key == dec_key_reg) || (inflight_dec_reg == '0));
    assign req_ready  = run_reg && credit_ok && key_ok;
    assign issue      = req_valid && req_ready;

    assign rsp_valid  = (fifo_count_reg != '0);
    assign pop        = rsp_valid && rsp_ready;
    assign rsp_data   = mem_data[rd_ptr_reg];
    assign rsp_mode   = mem_mode[rd_ptr_reg];

    // Results arriving with nothing in flight on that codec are strays and are dropped.
    assign enc_take = enc_valid_o && (inflight_enc_reg != '0);
    assign dec_live = dec_valid_o && (inflight_dec_reg != '0);
`ifdef DES_SCHED_ERR_EN
    assign dec_take = dec_live;
`else
    assign dec_take = dec_live && !enc_valid_o;
`endif

    assign free_slots  = SW'(DEPTH) - SW'(fifo_count_reg) + SW'(pop);
    assign push0       = (enc_take || dec_take) && (free_slots != '0);
    assign push1       = enc_take && dec_take && (free_slots >= SW'(2));
    assign n_push      = {1'b0, push0} + {1'b0, push1};
    assign slot0_data  = enc_take ? enc_data_o : dec_data_o;
    assign slot0_mode  = enc_take;
    assign wr_ptr_nxt1 = wr_ptr_reg + PW'(1);

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_wen
            assign wen0[gi] = push0 && (wr_ptr_reg == PW'(gi));
            assign wen1[gi] = push1 && (wr_ptr_nxt1 == PW'(gi));
        end
    endgenerate

    assign enc_data_i  = enc_data_i_reg;
    assign enc_valid_i = enc_valid_i_reg;
    assign enc_key     = enc_key_reg;
    assign dec_data_i  = dec_data_i_reg;
    assign dec_valid_i = dec_valid_i_reg;
    assign dec_key     = dec_key_reg;

    // Issue registers: one-cycle valid pulse, data/key loaded only on issue and held otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_reg         <= 1'b0;
            enc_valid_i_reg <= 1'b0;
            dec_valid_i_reg <= 1'b0;
            enc_data_i_reg  <= '0;
            dec_data_i_reg  <= '0;
            enc_key_reg     <= '0;
            dec_key_reg     <= '0;
        end else begin
            run_reg         <= 1'b1;
            enc_valid_i_reg <= issue && req_mode;
            dec_valid_i_reg <= issue && !req_mode;
            if (issue && req_mode) begin
                enc_data_i_reg <= req_data;
                enc_key_reg    <= req_key;
            end
            if (issue && !req_mode) begin
                dec_data_i_reg <= req_data;
                dec_key_reg    <= req_key;
            end
        end
    end

    // In-flight counters: up on issue, down when that codec returns a live result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_enc_reg <= '0;
            inflight_dec_reg <= '0;
        end else begin
            inflight_enc_reg <= inflight_enc_reg + IW'(issue && req_mode) - IW'(enc_take);
            inflight_dec_reg <= inflight_dec_reg + IW'(issue && !req_mode) - IW'(dec_live);
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at the power-of-2 depth.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            fifo_count_reg <= '0;
        end else begin
            wr_ptr_reg     <= wr_ptr_reg + PW'(n_push);
            rd_ptr_reg     <= rd_ptr_reg + PW'(pop);
            fifo_count_reg <= fifo_count_reg + CW'(n_push) - CW'(pop);
        end
    end

    // FIFO storage: slot 0 takes enc (or dec), slot 1 takes dec when both arrive together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_data[i] <= '0;
                mem_mode[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wen0[i]) begin
                    mem_data[i] <= slot0_data;
                    mem_mode[i] <= slot0_mode;
                end else if (wen1[i]) begin
                    mem_data[i] <= dec_data_o;
                    mem_mode[i] <= 1'b0;
                end
            end
        end
    end

`ifdef DES_SCHED_ERR_EN
    logic err_reg;
    assign err = err_reg;

    // Sticky error: simultaneous codec results or a result with nothing in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_reg <= 1'b0;
        end else if ((enc_valid_o && dec_valid_o) ||
                     (enc_valid_o && (inflight_enc_reg == '0)) ||
                     (dec_valid_o && (inflight_dec_reg == '0))) begin
            err_reg <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_des_sched.sv
// tb_des_sched: directed plus randomized checks of des_sched against a queue
// scoreboard and fixed-latency behavioural codec models.
`timescale 1ns/1ps
module tb_des_sched;
    localparam int LAT   = 17;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0, req_mode = 1'b0, rsp_ready = 1'b0;
    logic [63:0] req_data = '0, req_key = '0;
    logic        req_ready, rsp_valid, rsp_mode;
    logic [63:0] rsp_data;
    logic [63:0] enc_data_i, enc_key, dec_data_i, dec_key;
    logic        enc_valid_i, dec_valid_i;
    logic [63:0] enc_data_o, dec_data_o;
    logic        enc_valid_o, dec_valid_o;
    logic        inj_enc = 1'b0;
`ifdef DES_SCHED_ERR_EN
    logic        err;
`endif

    int comps = 0;
    int mism  = 0;
    int n_rsp = 0;
    logic rnd_rsp = 1'b0;

    always #5 clk = ~clk;

    des_sched #(.LAT(LAT), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_data(req_data), .req_key(req_key), .req_mode(req_mode),
        .enc_data_i(enc_data_i), .enc_valid_i(enc_valid_i), .enc_key(enc_key),
        .enc_data_o(enc_data_o), .enc_valid_o(enc_valid_o),
        .dec_data_i(dec_data_i), .dec_valid_i(dec_valid_i), .dec_key(dec_key),
        .dec_data_o(dec_data_o), .dec_valid_o(dec_valid_o),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_mode(rsp_mode)
`ifdef DES_SCHED_ERR_EN
        , .err(err)
`endif
    );

    function automatic logic [63:0] enc_fn(input logic [63:0] d, input logic [63:0] k);
        return {d[31:0], d[63:32]} ^ k ^ 64'h0F1E2D3C4B5A6978;
    endfunction

    function automatic logic [63:0] dec_fn(input logic [63:0] d, input logic [63:0] k);
        return ~d ^ {k[7:0], k[63:8]};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        comps++;
        assert (obs === exp) else begin
            mism++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_true(input string tag, input logic cond);
        comps++;
        assert (cond === 1'b1) else begin
            mism++;
            $error("FAIL %s: observed=%b expected=1", tag, cond);
        end
    endtask

    // Behavioural codecs: fixed LAT-cycle pipelines sharing rst_n with the scheduler.
    logic [LAT-1:0] e_pipe, d_pipe;
    logic [63:0]    e_dat [LAT];
    logic [63:0]    e_k   [LAT];
    logic [63:0]    d_dat [LAT];
    logic [63:0]    d_k   [LAT];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_pipe <= '0;
            d_pipe <= '0;
        end else begin
            e_pipe   <= {e_pipe[LAT-2:0], enc_valid_i};
            d_pipe   <= {d_pipe[LAT-2:0], dec_valid_i};
            e_dat[0] <= enc_data_i;
            e_k[0]   <= enc_key;
            d_dat[0] <= dec_data_i;
            d_k[0]   <= dec_key;
            for (int s = 1; s < LAT; s++) begin
                e_dat[s] <= e_dat[s-1];
                e_k[s]   <= e_k[s-1];
                d_dat[s] <= d_dat[s-1];
                d_k[s]   <= d_k[s-1];
            end
        end
    end

    assign enc_valid_o = e_pipe[LAT-1] | inj_enc;
    assign dec_valid_o = d_pipe[LAT-1];
    assign enc_data_o  = enc_fn(e_dat[LAT-1], e_k[LAT-1]);
    assign dec_data_o  = dec_fn(d_dat[LAT-1], d_k[LAT-1]);

    // Scoreboard: expected results queued in acceptance order, compared on every pop.
    logic [64:0] exp_q [$];
    logic [64:0] sb_head;

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            if (req_valid && req_ready)
                exp_q.push_back(req_mode ? {enc_fn(req_data, req_key), 1'b1}
                                         : {dec_fn(req_data, req_key), 1'b0});
            if (rsp_valid && rsp_ready) begin
                chk_true("rsp_expected", exp_q.size() != 0);
                if (exp_q.size() != 0) begin
                    sb_head = exp_q.pop_front();
                    chk("rsp_data", rsp_data, sb_head[64:1]);
                    chk("rsp_mode", {63'd0, rsp_mode}, {63'd0, sb_head[0]});
                    $display("rsp #%0d mode=%0d data=%h", n_rsp, rsp_mode, rsp_data);
                    n_rsp++;
                end
            end
            if (e_pipe[LAT-1]) chk("enc_key_hold", enc_key, e_k[LAT-1]);
            if (d_pipe[LAT-1]) chk("dec_key_hold", dec_key, d_k[LAT-1]);
        end
    end

    task automatic send(input logic m, input logic [63:0] k, input logic [63:0] d);
        int n = 0;
        req_valid = 1'b1; req_mode = m; req_key = k; req_data = d;
        #1;
        while (!req_ready && n < 400) begin
            @(posedge clk); #1;
            if (rnd_rsp) rsp_ready = 1'($urandom_range(0, 1));
            #1;
            n++;
        end
        chk_true("send_timeout", n < 400);
        @(posedge clk); #1;
        req_valid = 1'b0;
        if (rnd_rsp) rsp_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic drain(input int budget);
        int n = 0;
        rsp_ready = 1'b1;
        while ((exp_q.size() != 0 || rsp_valid) && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        chk_true("drain_timeout", n < budget);
    endtask

    logic [63:0] k1, d1, k2, k3a, k3b;
    logic [63:0] dq [7];
    logic [63:0] key_pool [4];
    logic        acc;
    int          idx, dv, base;

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_enc_valid_i", {63'd0, enc_valid_i}, 64'd0);
        chk("rst_dec_valid_i", {63'd0, dec_valid_i}, 64'd0);
        chk("rst_enc_key", enc_key, 64'd0);
        chk("rst_dec_key", dec_key, 64'd0);
        chk("rst_enc_data_i", enc_data_i, 64'd0);
        chk("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        chk("rst_req_ready", {63'd0, req_ready}, 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_ready", {63'd0, req_ready}, 64'd1);

        // Test 1: single encrypt and its latency
        k1 = 64'h133457799BBCDFF1;
        d1 = 64'h0123456789ABCDEF;
        req_valid = 1'b1; req_mode = 1'b1; req_key = k1; req_data = d1;
        #1;
        chk("t1_ready", {63'd0, req_ready}, 64'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("t1_enc_valid_i", {63'd0, enc_valid_i}, 64'd1);
        chk("t1_enc_data_i", enc_data_i, d1);
        chk("t1_enc_key", enc_key, k1);
        chk("t1_dec_valid_i", {63'd0, dec_valid_i}, 64'd0);
        @(posedge clk); #1;
        chk("t1_pulse", {63'd0, enc_valid_i}, 64'd0);
        repeat (LAT - 1) @(posedge clk);
        #1;
        chk("t1_rsp_not_early", {63'd0, rsp_valid}, 64'd0);
        @(posedge clk); #1;
        chk("t1_rsp_valid", {63'd0, rsp_valid}, 64'd1);
        chk("t1_rsp_mode", {63'd0, rsp_mode}, 64'd1);
        chk("t1_rsp_data", rsp_data, enc_fn(d1, k1));
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk("t1_popped", {63'd0, rsp_valid}, 64'd0);

        // Test 2: credit exhaustion with rsp_ready low
        k2 = {$urandom, $urandom};
        for (int i = 0; i < 7; i++) dq[i] = {$urandom, $urandom};
        idx = 0; dv = 0;
        req_valid = 1'b1; req_mode = 1'b0; req_key = k2; req_data = dq[0];
        for (int c = 0; c < 6; c++) begin
            #1;
            acc = req_ready;
            chk($sformatf("t2_ready_c%0d", c), {63'd0, acc}, (c < 4) ? 64'd1 : 64'd0);
            @(posedge clk); #1;
            if (acc) begin
                idx++;
                req_data = dq[idx];
            end
            dv += int'(dec_valid_i);
        end
        chk("t2_dec_valid_cycles", 64'(dv), 64'd4);
        repeat (LAT + 2) @(posedge clk);
        #1;
        chk("t2_full_stall", {63'd0, req_ready}, 64'd0);
        for (int p = 0; p < 2; p++) begin
            rsp_ready = 1'b1;
            @(posedge clk); #1;
            rsp_ready = 1'b0;
            #1;
            chk($sformatf("t2_ready_after_pop%0d", p), {63'd0, req_ready}, 64'd1);
            @(posedge clk); #1;
            chk($sformatf("t2_issue_valid%0d", p), {63'd0, dec_valid_i}, 64'd1);
            chk($sformatf("t2_issue_data%0d", p), dec_data_i, dq[4 + p]);
            idx++;
            req_data = dq[idx];
            #1;
            chk($sformatf("t2_stall_again%0d", p), {63'd0, req_ready}, 64'd0);
        end
        req_valid = 1'b0;
        drain(400);

        // Test 3: key change stalls until the encrypt codec is empty
        k3a = {$urandom, $urandom};
        k3b = ~k3a;
        req_valid = 1'b1; req_mode = 1'b1; req_key = k3a; req_data = {$urandom, $urandom};
        #1;
        chk("t3_first_ready", {63'd0, req_ready}, 64'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("t3_first_issue", {63'd0, enc_valid_i}, 64'd1);
        for (int c = 1; c <= LAT + 1; c++) begin
            chk($sformatf("t3_key_hold_c%0d", c), enc_key, k3a);
            if (c == 3) begin
                req_valid = 1'b1; req_key = k3b; req_data = {$urandom, $urandom};
            end
            if (c >= 3) begin
                #1;
                chk($sformatf("t3_stall_c%0d", c), {63'd0, req_ready}, 64'd0);
            end
            @(posedge clk); #1;
        end
        #1;
        chk("t3_ready_after_empty", {63'd0, req_ready}, 64'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("t3_second_issue", {63'd0, enc_valid_i}, 64'd1);
        chk("t3_second_key", enc_key, k3b);
        drain(400);

        // Test 4: alternating encrypt/decrypt, responses in request order
        k1 = {$urandom, $urandom};
        k2 = {$urandom, $urandom};
        base = n_rsp;
        for (int i = 0; i < 8; i++)
            send((i % 2) == 0, ((i % 2) == 0) ? k1 : k2, {$urandom, $urandom});
        drain(400);
        chk("t4_count", 64'(n_rsp - base), 64'd8);

        // Randomized phase: random modes, small key pool, random response backpressure
        for (int i = 0; i < 4; i++) key_pool[i] = {$urandom, $urandom};
        base = n_rsp;
        rnd_rsp = 1'b1;
        for (int i = 0; i < 40; i++) begin
            acc = 1'($urandom_range(0, 1));
            send(acc, key_pool[{acc, 1'($urandom_range(0, 1))}], {$urandom, $urandom});
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        rnd_rsp = 1'b0;
        drain(800);
        chk("rand_count", 64'(n_rsp - base), 64'd40);

        // Test 5: reset mid-operation discards in-flight work
        rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) send(1'b1, k1, {$urandom, $urandom});
        repeat (8) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t5_enc_valid_i", {63'd0, enc_valid_i}, 64'd0);
        chk("t5_enc_key", enc_key, 64'd0);
        chk("t5_enc_data_i", enc_data_i, 64'd0);
        chk("t5_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        chk("t5_rsp_data", rsp_data, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("t5_ready_release", {63'd0, req_ready}, 64'd1);
        for (int c = 0; c < LAT + 4; c++) begin
            @(posedge clk); #1;
            chk($sformatf("t5_no_late_rsp_c%0d", c), {63'd0, rsp_valid}, 64'd0);
        end
`ifdef DES_SCHED_ERR_EN
        chk("t5_err_clear", {63'd0, err}, 64'd0);

        // Test 6: stray encrypt result sets sticky err and leaves the FIFO alone
        inj_enc = 1'b1;
        @(posedge clk); #1;
        inj_enc = 1'b0;
        chk("t6_err_set", {63'd0, err}, 64'd1);
        chk("t6_fifo_empty", {63'd0, rsp_valid}, 64'd0);
        repeat (5) @(posedge clk);
        #1;
        chk("t6_err_sticky", {63'd0, err}, 64'd1);
        rst_n = 1'b0;
        #1;
        chk("t6_err_reset", {63'd0, err}, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", comps, mism);
        $finish;
    end

endmodule
